// File: rtl/dsp_addsub_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit DSP add/sub between two
// requesters, with a registered result slot per requester and a contention counter.
module dsp_addsub_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_carry,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_carry,

    output logic [WIDTH-1:0] dsp_input1,
    output logic [WIDTH-1:0] dsp_input2,
    output logic             dsp_sub,
    input  logic [WIDTH-1:0] dsp_out,
    input  logic             dsp_carry,

    output logic [CNT_W-1:0] contention_cnt
);

    localparam int unsigned INC_W = 2;

    logic             elig0;
    logic             elig1;
    logic             grant0;
    logic             grant1;
    logic             last_grant;
    logic [INC_W-1:0] cont_inc;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_next;

    // A full result slot blocks only its own requester; nothing is granted during reset.
    always_comb begin
        elig0 = 1'b0;
        elig1 = 1'b0;
        if (!reset) begin
            elig0 = req0_valid && (!rsp0_valid || rsp0_ready);
            elig1 = req1_valid && (!rsp1_valid || rsp1_ready);
        end
    end

    // On conflict the requester that did not win most recently gets the DSP.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            if (last_grant) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        dsp_input1 = '0;
        dsp_input2 = '0;
        dsp_sub    = 1'b0;
        if (grant0) begin
            dsp_input1 = req0_a;
            dsp_input2 = req0_b;
            dsp_sub    = req0_sub;
        end else if (grant1) begin
            dsp_input1 = req1_a;
            dsp_input2 = req1_b;
            dsp_sub    = req1_sub;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

    // Result slot 0: new accept overrides consume, so throughput stays 1/cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_carry <= 1'b0;
        end else if (grant0) begin
            rsp0_valid <= 1'b1;
            rsp0_data  <= dsp_out;
            rsp0_carry <= dsp_carry;
        end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_carry <= 1'b0;
        end else if (grant1) begin
            rsp1_valid <= 1'b1;
            rsp1_data  <= dsp_out;
            rsp1_carry <= dsp_carry;
        end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
        end
    end

    // Saturating add of 0..2 waiting requesters; the extra sum bit flags overflow.
    always_comb begin
        cont_inc = INC_W'(req0_valid && !grant0) + INC_W'(req1_valid && !grant1);
        cnt_sum  = {1'b0, contention_cnt} + (CNT_W+1)'(cont_inc);
        cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            contention_cnt <= '0;
        end else begin
            contention_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_dsp_addsub_arbiter.sv
// Bench for dsp_addsub_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_dsp_addsub_arbiter;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = 15;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp0_carry;
    logic [31:0] rsp0_data;
    logic        rsp1_valid, rsp1_ready, rsp1_carry;
    logic [31:0] rsp1_data;
    logic [31:0] dsp_input1, dsp_input2, dsp_out;
    logic        dsp_sub, dsp_carry;
    logic [CNT_W-1:0] contention_cnt;

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";
    int    cyc     = 0;

    dsp_addsub_arbiter #(.WIDTH(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_carry(rsp0_carry),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_carry(rsp1_carry),
        .dsp_input1(dsp_input1), .dsp_input2(dsp_input2), .dsp_sub(dsp_sub),
        .dsp_out(dsp_out), .dsp_carry(dsp_carry),
        .contention_cnt(contention_cnt)
    );

    // Stand-in for the bypassed SB_MAC16 add/sub.
    always_comb begin
        if (dsp_sub) begin
            dsp_out   = dsp_input1 - dsp_input2;
            dsp_carry = (dsp_input1 >= dsp_input2);
        end else begin
            {dsp_carry, dsp_out} = {1'b0, dsp_input1} + {1'b0, dsp_input2};
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s cyc=%0d: got %b expected %b", phase, name, cyc, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s cyc=%0d: got %h expected %h", phase, name, cyc, act, exp);
        end
    endtask

    task automatic chk_n(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s cyc=%0d: got %0d expected %0d", phase, name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic s0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic s1,
                         input logic r0, input logic r1);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
        rsp0_ready = r0; rsp1_ready = r1;
    endtask

    task automatic idle(input logic r0, input logic r1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, r0, r1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Full observation check; data/carry only matter while the slot is valid.
    task automatic check_obs(input logic er0, input logic er1,
                             input logic ev0, input logic [31:0] ed0, input logic ec0,
                             input logic ev1, input logic [31:0] ed1, input logic ec1,
                             input logic [CNT_W-1:0] ecnt,
                             input logic [31:0] eda, input logic [31:0] edb, input logic eds);
        chk_b("req0_ready", req0_ready, er0);
        chk_b("req1_ready", req1_ready, er1);
        chk_w("dsp_input1", dsp_input1, eda);
        chk_w("dsp_input2", dsp_input2, edb);
        chk_b("dsp_sub", dsp_sub, eds);
        chk_b("rsp0_valid", rsp0_valid, ev0);
        if (ev0) begin
            chk_w("rsp0_data", rsp0_data, ed0);
            chk_b("rsp0_carry", rsp0_carry, ec0);
        end
        chk_b("rsp1_valid", rsp1_valid, ev1);
        if (ev1) begin
            chk_w("rsp1_data", rsp1_data, ed1);
            chk_b("rsp1_carry", rsp1_carry, ec1);
        end
        chk_n("contention_cnt", contention_cnt, ecnt);
    endtask

    typedef struct {
        logic v0; logic [31:0] a0; logic [31:0] b0; logic s0;
        logic v1; logic [31:0] a1; logic [31:0] b1; logic s1;
        logic r0; logic r1;
        logic er0; logic er1;
        logic ev0; logic [31:0] ed0; logic ec0;
        logic ev1; logic [31:0] ed1; logic ec1;
        logic [CNT_W-1:0] ecnt;
    } vec_t;

    localparam int unsigned NVEC = 12;
    vec_t vecs [NVEC];

    function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [32:0] r;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + 33'd1;
        else     r = {1'b0, a} + {1'b0, b};
        return r;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0:       v = 32'h0;
            1:       v = 32'hFFFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    logic        m_v [2];
    logic [31:0] m_d [2];
    logic        m_c [2];
    int          m_last;
    int          m_cnt;
    logic        pend [2];
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    logic        ps [2];
    logic        rr [2];
    logic        el [2];
    logic        rst;
    int          g;
    int          waiting;
    int          acc0, acc1;
    int          exp_cnt, inc;
    logic [32:0] res;
    logic [31:0] eda, edb;
    logic        eds;

    initial begin
        vecs[0]  = '{1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'd3, 32'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                     1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0};
        vecs[1]  = '{1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd3, 32'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                     1'b1, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd1};
        vecs[2]  = '{1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                     1'b0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 4'd1};
        vecs[3]  = '{1'b1, 32'd5, 32'd3, 1'b1, 1'b1, 32'd10, 32'd20, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                     1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd1};
        vecs[4]  = '{1'b1, 32'd7, 32'd8, 1'b0, 1'b1, 32'd10, 32'd20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                     1'b1, 32'd2, 1'b1, 1'b0, 32'd0, 1'b0, 4'd2};
        vecs[5]  = '{1'b1, 32'd7, 32'd8, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                     1'b0, 32'd0, 1'b0, 1'b1, 32'd30, 1'b0, 4'd3};
        vecs[6]  = '{1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                     1'b1, 32'd15, 1'b0, 1'b0, 32'd0, 1'b0, 4'd3};
        vecs[7]  = '{1'b1, 32'd1, 32'd1, 1'b0, 1'b1, 32'd100, 32'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                     1'b1, 32'd15, 1'b0, 1'b0, 32'd0, 1'b0, 4'd3};
        vecs[8]  = '{1'b1, 32'd1, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                     1'b1, 32'd15, 1'b0, 1'b1, 32'd99, 1'b1, 4'd4};
        vecs[9]  = '{1'b1, 32'd1, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                     1'b1, 32'd15, 1'b0, 1'b0, 32'd0, 1'b0, 4'd5};
        vecs[10] = '{1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                     1'b1, 32'd2, 1'b0, 1'b0, 32'd0, 1'b0, 4'd5};
        vecs[11] = '{1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                     1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd5};

        // Reset state, with requests offered during reset.
        phase = "reset";
        reset = 1'b1;
        drive(1'b1, 32'd9, 32'd4, 1'b0, 1'b1, 32'd8, 32'd2, 1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check_obs(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk_w("rsp0_data_rst", rsp0_data, 32'd0);
        chk_w("rsp1_data_rst", rsp1_data, 32'd0);
        chk_b("rsp0_carry_rst", rsp0_carry, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle(1'b1, 1'b1);

        // Directed vector table.
        phase = "table";
        for (int i = 0; i < int'(NVEC); i++) begin
            @(negedge clk);
            cyc = i;
            drive(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].s0, vecs[i].v1, vecs[i].a1, vecs[i].b1,
                  vecs[i].s1, vecs[i].r0, vecs[i].r1);
            if (vecs[i].er0)      begin eda = vecs[i].a0; edb = vecs[i].b0; eds = vecs[i].s0; end
            else if (vecs[i].er1) begin eda = vecs[i].a1; edb = vecs[i].b1; eds = vecs[i].s1; end
            else                  begin eda = 32'd0; edb = 32'd0; eds = 1'b0; end
            #1;
            check_obs(vecs[i].er0, vecs[i].er1, vecs[i].ev0, vecs[i].ed0, vecs[i].ec0,
                      vecs[i].ev1, vecs[i].ed1, vecs[i].ec1, vecs[i].ecnt, eda, edb, eds);
        end

        // Single subtract, 1-cycle latency then slot empties.
        phase = "single";
        do_reset();
        @(negedge clk); cyc = 0;
        drive(1'b1, 32'd5, 32'd3, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        #1; chk_b("req0_ready", req0_ready, 1'b1);
        @(negedge clk); cyc = 1; idle(1'b1, 1'b1);
        #1; chk_b("rsp0_valid", rsp0_valid, 1'b1);
        chk_w("rsp0_data", rsp0_data, 32'd2);
        chk_b("rsp0_carry", rsp0_carry, 1'b1);
        @(negedge clk); cyc = 2;
        #1; chk_b("rsp0_valid_clr", rsp0_valid, 1'b0);

        // Sustained contention alternates strictly.
        phase = "alternate";
        do_reset();
        acc0 = 0; acc1 = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); cyc = k;
            drive(1'b1, 32'(k), 32'd1, 1'b0, 1'b1, 32'(k), 32'd2, 1'b1, 1'b1, 1'b1);
            #1;
            chk_b("req0_ready", req0_ready, (k % 2) == 0);
            chk_b("req1_ready", req1_ready, (k % 2) == 1);
            if (req0_ready) acc0++;
            if (req1_ready) acc1++;
        end
        @(negedge clk); idle(1'b1, 1'b1);
        #1;
        n_tests++;
        if (acc0 != 4 || acc1 != 4) begin
            n_fail++;
            $display("FAIL alternate/accepts: got %0d/%0d expected 4/4", acc0, acc1);
        end
        chk_n("contention_cnt", contention_cnt, 4'd8);

        // Blocked result slot stalls only its own requester.
        phase = "backpressure";
        do_reset();
        @(negedge clk); cyc = 0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h1000, 32'h234, 1'b0, 1'b1, 1'b1);
        #1; chk_b("req1_ready", req1_ready, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); cyc = k;
            drive(1'b1, 32'(k), 32'd1, 1'b0, 1'b1, 32'd5, 32'd5, 1'b0, 1'b1, 1'b0);
            #1;
            chk_b("req1_ready", req1_ready, 1'b0);
            chk_b("req0_ready", req0_ready, 1'b1);
            chk_b("rsp1_valid", rsp1_valid, 1'b1);
            chk_w("rsp1_data", rsp1_data, 32'h1234);
        end
        @(negedge clk); cyc = 4;
        drive(1'b1, 32'd9, 32'd1, 1'b0, 1'b1, 32'd5, 32'd5, 1'b0, 1'b1, 1'b1);
        #1;
        chk_b("req1_ready", req1_ready, 1'b1);
        chk_b("req0_ready", req0_ready, 1'b0);
        chk_w("rsp1_data", rsp1_data, 32'h1234);
        @(negedge clk); cyc = 5; idle(1'b1, 1'b1);
        #1;
        chk_b("rsp1_valid", rsp1_valid, 1'b1);
        chk_w("rsp1_data_new", rsp1_data, 32'd10);
        @(negedge clk); cyc = 6;
        #1; chk_b("rsp1_valid_clr", rsp1_valid, 1'b0);

        // Counter saturates, including the +2 step from 14.
        phase = "saturate";
        do_reset();
        exp_cnt = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk); cyc = k;
            drive(1'b1, 32'd1, 32'd2, 1'b0, 1'b1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
            #1;
            chk_n("contention_cnt", contention_cnt, CNT_W'(exp_cnt));
            inc = (k < 2) ? 1 : 2;
            exp_cnt = (exp_cnt + inc > int'(CNT_MAX)) ? int'(CNT_MAX) : exp_cnt + inc;
        end

        // Reset in the cycle after an accept drops the result and re-arms priority.
        phase = "reset_mid";
        do_reset();
        @(negedge clk); cyc = 0;
        drive(1'b1, 32'd1, 32'd2, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #1; chk_b("req0_ready", req0_ready, 1'b1);
        @(negedge clk); cyc = 1;
        reset = 1'b1;
        drive(1'b1, 32'd3, 32'd4, 1'b0, 1'b1, 32'd5, 32'd6, 1'b0, 1'b1, 1'b1);
        #1;
        chk_b("req0_ready_rst", req0_ready, 1'b0);
        chk_b("req1_ready_rst", req1_ready, 1'b0);
        chk_w("dsp_input1_rst", dsp_input1, 32'd0);
        @(negedge clk); cyc = 2;
        reset = 1'b0;
        #1;
        chk_b("rsp0_valid", rsp0_valid, 1'b0);
        chk_w("rsp0_data", rsp0_data, 32'd0);
        chk_n("contention_cnt", contention_cnt, 4'd0);
        chk_b("req0_ready", req0_ready, 1'b1);
        chk_b("req1_ready", req1_ready, 1'b0);

        // Randomized run against the transaction-level model.
        phase = "random";
        do_reset();
        for (int i = 0; i < 2; i++) begin
            m_v[i] = 1'b0; m_d[i] = 32'd0; m_c[i] = 1'b0; pend[i] = 1'b0;
            pa[i] = 32'd0; pb[i] = 32'd0; ps[i] = 1'b0;
        end
        m_last = 1; m_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk); cyc = c;
            rst = ($urandom_range(0, 99) < 2);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 60) begin
                    pend[i] = 1'b1; pa[i] = pick(); pb[i] = pick(); ps[i] = 1'($urandom_range(0, 1));
                end
                rr[i] = ($urandom_range(0, 99) < 70);
                el[i] = !rst && pend[i] && (!m_v[i] || rr[i]);
            end
            reset = rst;
            drive(pend[0], pa[0], pb[0], ps[0], pend[1], pa[1], pb[1], ps[1], rr[0], rr[1]);
            if (el[0] && el[1]) g = 1 - m_last;
            else if (el[0])     g = 0;
            else if (el[1])     g = 1;
            else                g = -1;
            if (g >= 0) begin eda = pa[g]; edb = pb[g]; eds = ps[g]; end
            else        begin eda = 32'd0; edb = 32'd0; eds = 1'b0; end
            #1;
            check_obs(g == 0, g == 1, m_v[0], m_d[0], m_c[0], m_v[1], m_d[1], m_c[1],
                      CNT_W'(m_cnt), eda, edb, eds);
            if (rst) begin
                for (int i = 0; i < 2; i++) begin m_v[i] = 1'b0; m_d[i] = 32'd0; m_c[i] = 1'b0; end
                m_last = 1; m_cnt = 0;
            end else begin
                waiting = 0;
                for (int i = 0; i < 2; i++) begin
                    if (pend[i] && g != i) waiting++;
                    if (g == i) begin
                        res = ref_op(pa[i], pb[i], ps[i]);
                        m_v[i] = 1'b1; m_d[i] = res[31:0]; m_c[i] = res[32];
                        pend[i] = 1'b0;
                    end else if (rr[i]) begin
                        m_v[i] = 1'b0;
                    end
                end
                m_cnt = (m_cnt + waiting > int'(CNT_MAX)) ? int'(CNT_MAX) : m_cnt + waiting;
                if (g >= 0) m_last = g;
            end
        end
        @(negedge clk);
        reset = 1'b0;
        idle(1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
